// File: rtl/ariane_pkg.sv
// Shared fetch-path types: the fetch entry handed to the fetch FIFO and the
// RVC length decode used by both the realigner and the FIFO model.
package ariane_pkg;

  localparam int unsigned FETCH_ADDR_W = 64;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] addr;
    logic [31:0]             instr;
    logic                    is_compressed;
  } fetch_entry_t;

  // Any halfword whose two low bits are not 2'b11 starts a 16-bit instruction.
  function automatic logic is_compressed(input logic [15:0] halfword);
    return (halfword[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/instr_realigner.sv
// Splits 32-bit fetch words into aligned 16/32-bit instructions, carrying the
// low half of a 32-bit instruction that straddles two fetch words.
module instr_realigner
  import ariane_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [31:0]           in_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           out_instr_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  out_is_compressed_o
);

  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  idx_q, idx_d;
  logic [15:0]           hw_q, hw_d;
  logic [ADDR_WIDTH-1:0] hw_addr_q, hw_addr_d;
  logic                  pending_q, pending_d;

  logic                  consume;
  logic                  in_ready;
  logic                  out_valid;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_comp;

  logic [15:0]           lo_half;
  logic [15:0]           hi_half;
  logic [ADDR_WIDTH-1:0] upper_addr;
  logic [ADDR_WIDTH-1:0] in_word_addr;
  logic                  unused_addr_bit;

  assign lo_half         = word_q[15:0];
  assign hi_half         = word_q[31:16];
  assign upper_addr      = addr_q + ADDR_WIDTH'(2);
  // The word register always holds the word-aligned address; idx selects the half.
  assign in_word_addr    = {in_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign unused_addr_bit = in_addr_i[0];

  always_comb begin
    word_d    = word_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    hw_d      = hw_q;
    hw_addr_d = hw_addr_q;
    pending_d = pending_q;
    consume   = 1'b0;
    out_valid = 1'b0;
    out_instr = 32'h0;
    out_addr  = '0;
    out_comp  = 1'b0;

    if (valid_q) begin
      if (pending_q) begin
        out_valid = 1'b1;
        out_instr = {lo_half, hw_q};
        out_addr  = hw_addr_q;
        if (out_ready_i) begin
          pending_d = 1'b0;
          idx_d     = 1'b1;
        end
      end else if (!idx_q) begin
        out_valid = 1'b1;
        out_addr  = addr_q;
        if (is_compressed(lo_half)) begin
          out_instr = {16'h0, lo_half};
          out_comp  = 1'b1;
          if (out_ready_i) idx_d = 1'b1;
        end else begin
          out_instr = word_q;
          consume   = out_ready_i;
        end
      end else if (is_compressed(hi_half)) begin
        out_valid = 1'b1;
        out_instr = {16'h0, hi_half};
        out_addr  = upper_addr;
        out_comp  = 1'b1;
        consume   = out_ready_i;
      end else begin
        // Upper half opens a 32-bit instruction: park it and wait for the next word.
        hw_d      = hi_half;
        hw_addr_d = upper_addr;
        pending_d = 1'b1;
        consume   = 1'b1;
      end
    end

    if (consume) valid_d = 1'b0;
    in_ready = !valid_q || consume;

    if (in_valid_i && in_ready) begin
      word_d  = in_rdata_i;
      addr_d  = in_word_addr;
      valid_d = 1'b1;
      idx_d   = in_addr_i[1];
    end

    if (flush_i) begin
      valid_d   = 1'b0;
      pending_d = 1'b0;
      idx_d     = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end

    if (rst_i) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_instr = 32'h0;
      out_addr  = '0;
      out_comp  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q    <= 32'h0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= 1'b0;
      hw_q      <= 16'h0;
      hw_addr_q <= '0;
      pending_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      hw_q      <= hw_d;
      hw_addr_q <= hw_addr_d;
      pending_q <= pending_d;
    end
  end

  assign in_ready_o          = in_ready;
  assign out_valid_o         = out_valid;
  assign out_instr_o         = out_instr;
  assign out_addr_o          = out_addr;
  assign out_is_compressed_o = out_comp;

endmodule

// File: tb/tb_instr_realigner.sv
// Directed bench for instr_realigner: inputs change 1 ns after each rising
// edge, outputs are checked 2 ns after it.
module tb_instr_realigner;

  localparam int unsigned AW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [31:0]   in_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_comp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_realigner #(.ADDR_WIDTH(AW)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .in_addr_i          (in_addr),
    .in_rdata_i         (in_rdata),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .out_instr_o        (out_instr),
    .out_addr_o         (out_addr),
    .out_is_compressed_o(out_comp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] instr,
                         input logic [63:0] addr, input logic comp);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".instr"}, 64'(out_instr), 64'(instr));
    chk({tag, ".addr"},  out_addr, addr);
    chk({tag, ".comp"},  64'(out_comp), 64'(comp));
    $display("out %-12s instr=%h addr=%h comp=%0d", tag, out_instr, out_addr, out_comp);
  endtask

  task automatic offer(input logic [63:0] addr, input logic [31:0] data);
    in_valid = 1'b1;
    in_addr  = addr;
    in_rdata = data;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_addr  = '0;
    in_rdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    idle();
    tick(); tick();
    settle();
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd0);
    chk("rst.instr",     64'(out_instr), 64'd0);
    chk("rst.addr",      out_addr,       64'd0);
    chk("rst.comp",      64'(out_comp),  64'd0);

    // first cycle out of reset
    tick(); rst = 1'b0; settle();
    chk("post_rst.in_ready", 64'(in_ready), 64'd1);

    // single uncompressed word
    offer(64'h1000, 32'h00130413); settle();
    chk("w1.in_ready", 64'(in_ready), 64'd1);
    chk("w1.no_out",   64'(out_valid), 64'd0);
    tick(); idle(); settle();
    chk_out("w1", 32'h00130413, 64'h1000, 1'b0);
    chk("w1.in_ready2", 64'(in_ready), 64'd1);
    tick(); settle();
    chk("w1.idle", 64'(out_valid), 64'd0);

    // two compressed halves, next word taken on the second one
    offer(64'h2000, 32'h45014501);
    tick(); offer(64'h2004, 32'h00130413); settle();
    chk_out("cc.lo", 32'h00004501, 64'h2000, 1'b1);
    chk("cc.lo.in_ready", 64'(in_ready), 64'd0);
    tick(); settle();
    chk_out("cc.hi", 32'h00004501, 64'h2002, 1'b1);
    chk("cc.hi.in_ready", 64'(in_ready), 64'd1);
    tick(); idle(); settle();
    chk_out("cc.next", 32'h00130413, 64'h2004, 1'b0);
    tick(); settle();
    chk("cc.idle", 64'(out_valid), 64'd0);

    // compressed then spanning instruction
    offer(64'h3000, 32'h04134501);
    tick(); offer(64'h3004, 32'h00000013); settle();
    chk_out("sp.c", 32'h00004501, 64'h3000, 1'b1);
    tick(); settle();
    chk("sp.stash.valid",    64'(out_valid), 64'd0);
    chk("sp.stash.in_ready", 64'(in_ready),  64'd1);
    tick(); idle(); settle();
    chk_out("sp.span", 32'h00130413, 64'h3002, 1'b0);
    tick(); settle();
    chk_out("sp.tail", 32'h00000000, 64'h3006, 1'b1);
    tick(); settle();
    chk("sp.idle", 64'(out_valid), 64'd0);

    // fetch starting at upper halfword: low half never emitted
    offer(64'h4002, 32'h0413ABCD);
    tick(); offer(64'h4004, 32'h00000013); settle();
    chk("up.stash.valid",    64'(out_valid), 64'd0);
    chk("up.stash.in_ready", 64'(in_ready),  64'd1);
    tick(); idle(); settle();
    chk_out("up.span", 32'h00130413, 64'h4002, 1'b0);
    tick(); settle();
    chk_out("up.tail", 32'h00000000, 64'h4006, 1'b1);
    tick(); settle();
    chk("up.idle", 64'(out_valid), 64'd0);

    // flush while a halfword is pending
    offer(64'h5802, 32'h0413ABCD);
    tick(); idle(); settle();
    chk("fl.stash.valid", 64'(out_valid), 64'd0);
    tick(); settle();
    chk("fl.pend.valid",    64'(out_valid), 64'd0);
    chk("fl.pend.in_ready", 64'(in_ready),  64'd1);
    flush = 1'b1; offer(64'h5804, 32'h00000013); settle();
    chk("fl.valid",    64'(out_valid), 64'd0);
    chk("fl.in_ready", 64'(in_ready),  64'd0);
    tick(); flush = 1'b0; offer(64'h5000, 32'h00130413); settle();
    chk("fl.after.valid",    64'(out_valid), 64'd0);
    chk("fl.after.in_ready", 64'(in_ready),  64'd1);
    tick(); idle(); settle();
    chk_out("fl.fresh", 32'h00130413, 64'h5000, 1'b0);
    tick(); settle();
    chk("fl.idle", 64'(out_valid), 64'd0);

    // backpressure holds outputs
    offer(64'h6000, 32'h45014501);
    tick(); idle(); out_ready = 1'b0; settle();
    for (int i = 0; i < 5; i++) begin
      chk_out("bp.hold", 32'h00004501, 64'h6000, 1'b1);
      chk("bp.in_ready", 64'(in_ready), 64'd0);
      tick(); settle();
    end
    out_ready = 1'b1; settle();
    chk_out("bp.lo", 32'h00004501, 64'h6000, 1'b1);
    tick(); settle();
    chk_out("bp.hi", 32'h00004501, 64'h6002, 1'b1);
    tick(); settle();
    chk("bp.idle", 64'(out_valid), 64'd0);

    // reset mid-operation discards the buffered word
    offer(64'h7000, 32'h45014501);
    tick(); idle(); settle();
    chk_out("mr.pre", 32'h00004501, 64'h7000, 1'b1);
    rst = 1'b1; settle();
    chk("mr.valid",    64'(out_valid), 64'd0);
    chk("mr.in_ready", 64'(in_ready),  64'd0);
    chk("mr.instr",    64'(out_instr), 64'd0);
    tick(); rst = 1'b0; settle();
    chk("mr.after.valid",    64'(out_valid), 64'd0);
    chk("mr.after.in_ready", 64'(in_ready),  64'd1);
    tick(); settle();
    chk("mr.idle", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
